// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared funct3 size codes and access-unit state encoding
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mau_state_e;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/half of a memory word and extends it
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        fetch,
    output logic [31:0] ext
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        ext     = rdata;
        if (!fetch) begin
            case (funct3)
                F3_LB:   ext = {{24{b[7]}}, b};
                F3_LBU:  ext = {24'd0, b};
                F3_LH:   ext = {{16{h[15]}}, h};
                F3_LHU:  ext = {16'd0, h};
                default: ext = rdata;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store/fetch bridge between multicycle datapath and variable-latency memory
module mem_access_unit
    import riscv_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Fetch,
    input  logic [2:0]  funct3,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemStall,
    output logic        AccessErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    mau_state_e  state, state_nxt;
    logic [2:0]  f3_eff;
    logic        f3_ok, misalign, strobe, illegal, accept;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_off;
    logic        lat_fetch;
    logic [31:0] ext;

    // Fetches always behave as word loads regardless of funct3
    always_comb begin
        f3_eff   = Fetch ? F3_LW : funct3;
        f3_ok    = Fetch || (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW)
                         || (funct3 == F3_LBU) || (funct3 == F3_LHU);
        misalign = 1'b0;
        be       = 4'b1111;
        wdata    = WriteData;
        case (f3_eff)
            F3_LB, F3_LBU: begin
                be    = 4'b0001 << Adr[1:0];
                wdata = {4{WriteData[7:0]}};
            end
            F3_LH, F3_LHU: begin
                misalign = Adr[0];
                be       = 4'b0011 << Adr[1:0];
                wdata    = {2{WriteData[15:0]}};
            end
            F3_LW:   misalign = |Adr[1:0];
            default: misalign = 1'b0;
        endcase
        strobe    = MemRead | MemWrite;
        illegal   = (MemRead & MemWrite) | ~f3_ok | misalign;
        accept    = (state == ST_IDLE) && strobe && !illegal && !reset;
        AccessErr = (state == ST_IDLE) && strobe && illegal && !reset;
        MemStall  = accept || (state == ST_BUSY);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (mem_ready) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .funct3 (lat_f3),
        .off    (lat_off),
        .fetch  (lat_fetch),
        .ext    (ext)
    );

    // mem_addr/be/wdata keep their last values after completion; only req/we drop
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadData  <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            lat_f3    <= F3_LW;
            lat_off   <= 2'd0;
            lat_fetch <= 1'b0;
        end else if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {Adr[31:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wdata;
            lat_f3    <= f3_eff;
            lat_off   <= Adr[1:0];
            lat_fetch <= Fetch;
        end else if (state == ST_BUSY && mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) ReadData <= ext;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, Fetch;
    logic [2:0]  funct3;
    logic [31:0] Adr, WriteData;
    logic [31:0] ReadData;
    logic        MemStall, AccessErr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Fetch     (Fetch),
        .funct3    (funct3),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .MemStall  (MemStall),
        .AccessErr (AccessErr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Fetch     = 1'b0;
        funct3    = 3'b000;
        Adr       = 32'd0;
        WriteData = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
    endtask

    // Full accepted transaction; mem_ready is raised in BUSY cycle nbusy
    task automatic txn(input string tag, input logic rd, input logic wr, input logic fe,
                       input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int nbusy,
                       input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata);
        int stall_cycles;
        stall_cycles = 0;
        MemRead = rd; MemWrite = wr; Fetch = fe; funct3 = f3; Adr = adr; WriteData = wd;
        #1;
        check({tag, " accept stall"}, 32'(MemStall), 32'd1);
        check({tag, " accept err"}, 32'(AccessErr), 32'd0);
        check({tag, " accept req"}, 32'(mem_req), 32'd0);
        if (MemStall) stall_cycles++;
        for (int i = 1; i <= nbusy; i++) begin
            tick();
            if (i == nbusy) begin
                mem_ready = 1'b1;
                mem_rdata = rdat;
            end
            #1;
            check({tag, " busy req"}, 32'(mem_req), 32'd1);
            check({tag, " busy we"}, 32'(mem_we), 32'(wr));
            check({tag, " busy addr"}, mem_addr, e_addr);
            check({tag, " busy be"}, 32'(mem_be), 32'(e_be));
            if (wr) check({tag, " busy wdata"}, mem_wdata, e_wdata);
            if (MemStall) stall_cycles++;
        end
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_0000;
        MemRead = 1'b0; MemWrite = 1'b0; Fetch = 1'b0;
        #1;
        check({tag, " resp stall"}, 32'(MemStall), 32'd0);
        check({tag, " resp req"}, 32'(mem_req), 32'd0);
        check({tag, " stall cycles"}, 32'(stall_cycles), 32'(nbusy + 1));
    endtask

    task automatic bad_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] adr);
        MemRead = rd; MemWrite = wr; Fetch = 1'b0; funct3 = f3; Adr = adr;
        #1;
        check({tag, " err"}, 32'(AccessErr), 32'd1);
        check({tag, " stall"}, 32'(MemStall), 32'd0);
        check({tag, " req"}, 32'(mem_req), 32'd0);
        tick();
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        check({tag, " err pulse end"}, 32'(AccessErr), 32'd0);
        check({tag, " req after"}, 32'(mem_req), 32'd0);
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst ReadData", ReadData, 32'd0);
        check("rst MemStall", 32'(MemStall), 32'd0);
        check("rst AccessErr", 32'(AccessErr), 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        txn("fetch", 1, 0, 1, 3'b000, 32'h0000_0104, 32'd0, 32'h00A0_0093, 2,
            32'h0000_0104, 4'hF, 32'd0);
        check("fetch ReadData", ReadData, 32'h00A0_0093);
        tick();

        txn("lb", 1, 0, 0, 3'b000, 32'h0000_0203, 32'd0, 32'h80FF_1234, 1,
            32'h0000_0200, 4'b1000, 32'd0);
        check("lb ReadData", ReadData, 32'hFFFF_FF80);
        tick();

        txn("lbu", 1, 0, 0, 3'b100, 32'h0000_0203, 32'd0, 32'h80FF_1234, 1,
            32'h0000_0200, 4'b1000, 32'd0);
        check("lbu ReadData", ReadData, 32'h0000_0080);
        tick();

        txn("sh", 0, 1, 0, 3'b001, 32'h0000_0302, 32'hDEAD_BEEF, 32'h1111_1111, 2,
            32'h0000_0300, 4'b1100, 32'hBEEF_BEEF);
        check("sh ReadData kept", ReadData, 32'h0000_0080);
        tick();

        txn("lh", 1, 0, 0, 3'b001, 32'h0000_0202, 32'd0, 32'h80FF_1234, 1,
            32'h0000_0200, 4'b1100, 32'd0);
        check("lh ReadData", ReadData, 32'hFFFF_80FF);
        tick();

        txn("lhu", 1, 0, 0, 3'b101, 32'h0000_0200, 32'd0, 32'h80FF_1234, 1,
            32'h0000_0200, 4'b0011, 32'd0);
        check("lhu ReadData", ReadData, 32'h0000_1234);
        tick();

        bad_access("lw misaligned", 1, 0, 3'b010, 32'h0000_0101);
        bad_access("f3 011", 1, 0, 3'b011, 32'h0000_0100);
        bad_access("rd and wr", 1, 1, 3'b010, 32'h0000_0100);
        bad_access("lh odd", 1, 0, 3'b001, 32'h0000_0101);
        check("err ReadData kept", ReadData, 32'h0000_1234);

        // Reset in the second BUSY cycle
        MemRead = 1'b1; funct3 = 3'b010; Adr = 32'h0000_0400;
        tick();
        tick();
        check("rstbusy req before", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        check("rstbusy req", 32'(mem_req), 32'd0);
        check("rstbusy ReadData", ReadData, 32'd0);
        reset = 1'b0;
        MemRead = 1'b0;
        #1;
        check("rstbusy idle stall", 32'(MemStall), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ready = 1'b0;
        tick();
        check("late ready ReadData", ReadData, 32'd0);
        check("late ready req", 32'(mem_req), 32'd0);
        check("late ready stall", 32'(MemStall), 32'd0);

        txn("sb", 0, 1, 0, 3'b000, 32'h0000_0205, 32'h1234_5678, 32'd0, 1,
            32'h0000_0204, 4'b0010, 32'h7878_7878);
        check("sb ReadData kept", ReadData, 32'd0);
        tick();
        txn("lw b2b", 1, 0, 0, 3'b010, 32'h0000_0208, 32'd0, 32'hCAFE_F00D, 1,
            32'h0000_0208, 4'hF, 32'd0);
        check("lw b2b ReadData", ReadData, 32'hCAFE_F00D);
        tick();
        check("final ReadData hold", ReadData, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
